// File: rtl/c1541_gcr_shifter.sv
// GCR serial/parallel shifter between head emulation and the VIA byte-ready logic.
// Define GCR_BYTE_LATCH_EN to hold byte_n low until byte_ack instead of a timed pulse.
module c1541_gcr_shifter #(
  parameter int unsigned BYTE_PULSE = 2,
  parameter int unsigned SYNC_LEN   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       mode,
  input  logic       hclk,
  input  logic       hf,
  output logic       ht,
  input  logic       soe,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       sync_n,
  output logic       byte_n,
  input  logic       byte_ack
);

  localparam int unsigned RD_W = 10;
  localparam int unsigned WR_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned PT_W = 4;
  localparam logic [RD_W-1:0] SYNC_MASK = RD_W'((11'd1 << SYNC_LEN) - 11'd1);

  logic [RD_W-1:0]  rd_sr;
  logic [WR_W-1:0]  wr_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             mode_r;

  logic [RD_W-1:0]  n;
  logic             sync;
  logic             mode_chg;
  logic             rd_bit;
  logic             wr_bit;
  logic             byte_evt;

  // Strobe qualification; a mode change swallows a coincident hclk
  always_comb begin
    n        = {rd_sr[RD_W-2:0], hf};
    sync     = (n & SYNC_MASK) == SYNC_MASK;
    mode_chg = mode != mode_r;
    rd_bit   = hclk && !mode_chg && mode_r;
    wr_bit   = hclk && !mode_chg && !mode_r;
    byte_evt = ((rd_bit && !sync) || wr_bit) && (bit_cnt == CNT_W'(7));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sr   <= '0;
      wr_sr   <= '0;
      bit_cnt <= '0;
      mode_r  <= mode;
      ht      <= 1'b0;
      dout    <= 8'h00;
      sync_n  <= 1'b1;
    end else begin
      mode_r <= mode;
      if (mode_chg) begin
        bit_cnt <= '0;
        rd_sr   <= '0;
        sync_n  <= 1'b1;
        if (!mode) wr_sr <= din;
      end else if (rd_bit) begin
        rd_sr  <= n;
        sync_n <= !sync;
        if (sync) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) dout <= n[7:0];
        end
      end else if (wr_bit) begin
        ht      <= wr_sr[WR_W-1];
        bit_cnt <= bit_cnt + CNT_W'(1);
        sync_n  <= 1'b1;
        if (bit_cnt == CNT_W'(7)) wr_sr <= din;
        else                      wr_sr <= {wr_sr[WR_W-2:0], 1'b0};
      end
    end
  end

`ifdef GCR_BYTE_LATCH_EN
  logic unused;
  assign unused = ^{rd_sr[RD_W-1], ce, PT_W'(BYTE_PULSE)};

  // Byte-ready held until acknowledged; a fresh byte beats a coincident ack
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_n <= 1'b1;
    end else if (byte_evt && soe) begin
      byte_n <= 1'b0;
    end else if (byte_ack) begin
      byte_n <= 1'b1;
    end
  end
`else
  logic [PT_W-1:0] pt;
  logic            unused;
  assign unused = ^{rd_sr[RD_W-1], byte_ack};

  // Timed byte-ready pulse counted in ce ticks; a new byte reloads the timer
  always_ff @(posedge clk) begin
    if (reset) begin
      pt     <= '0;
      byte_n <= 1'b1;
    end else if (byte_evt && soe) begin
      pt     <= PT_W'(BYTE_PULSE);
      byte_n <= 1'b0;
    end else if (ce && (pt != '0)) begin
      pt <= pt - PT_W'(1);
      if (pt == PT_W'(1)) byte_n <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_c1541_gcr_shifter.sv
// Bench for c1541_gcr_shifter: directed vector table plus randomized run against a bit-history model.
module tb_c1541_gcr_shifter;

  localparam int unsigned BP = 2;
  localparam int unsigned SL = 10;

  logic       clk = 1'b0;
  logic       reset, ce, mode, hclk, hf, soe, byte_ack;
  logic [7:0] din;
  logic       ht, sync_n, byte_n;
  logic [7:0] dout;

  int checks = 0;
  int failures = 0;

  c1541_gcr_shifter #(.BYTE_PULSE(BP), .SYNC_LEN(SL)) dut (
    .clk(clk), .reset(reset), .ce(ce), .mode(mode), .hclk(hclk), .hf(hf),
    .ht(ht), .soe(soe), .din(din), .dout(dout), .sync_n(sync_n),
    .byte_n(byte_n), .byte_ack(byte_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, md, hc, hb, so, ce;
    logic [7:0] di;
    logic       e_ht;
    logic [7:0] e_dout;
    logic       e_sync_n, e_byte_n;
  } vec_t;

  vec_t tbl[$];

  // Reference model: bit history, trailing-ones run, bit position within a byte
  logic       m_mode;
  logic       m_ht, m_sync_n, m_byte_n;
  logic [7:0] m_dout;
  int         ones, bits, pulse_left, w_idx;
  logic [7:0] hist, w_byte;

  task automatic add(input logic rst, md, hc, hb, so, c, input logic [7:0] di,
                     input logic eht, input logic [7:0] edout, input logic esn, ebn);
    vec_t v;
    v.rst = rst; v.md = md; v.hc = hc; v.hb = hb; v.so = so; v.ce = c; v.di = di;
    v.e_ht = eht; v.e_dout = edout; v.e_sync_n = esn; v.e_byte_n = ebn;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic evt;
    evt = 1'b0;
    if (reset) begin
      m_ht = 0; m_dout = 8'h00; m_sync_n = 1; m_byte_n = 1; m_mode = mode;
      ones = 0; bits = 0; pulse_left = 0; w_idx = 0; hist = 8'h00; w_byte = 8'h00;
      return;
    end
    if (mode != m_mode) begin
      ones = 0; bits = 0; w_idx = 0; hist = 8'h00; m_sync_n = 1;
      if (!mode) w_byte = din;
      m_mode = mode;
    end else if (hclk && m_mode) begin
      hist = {hist[6:0], hf};
      ones = hf ? ones + 1 : 0;
      if (ones >= int'(SL)) begin
        m_sync_n = 0; bits = 0;
      end else begin
        m_sync_n = 1;
        bits++;
        if (bits == 8) begin bits = 0; m_dout = hist; evt = 1'b1; end
      end
    end else if (hclk && !m_mode) begin
      m_ht = w_byte[7 - w_idx];
      w_idx++;
      if (w_idx == 8) begin w_idx = 0; w_byte = din; evt = 1'b1; end
    end
`ifdef GCR_BYTE_LATCH_EN
    if (evt && soe) m_byte_n = 0;
    else if (byte_ack) m_byte_n = 1;
`else
    if (evt && soe) begin
      pulse_left = int'(BP); m_byte_n = 0;
    end else if (ce && pulse_left > 0) begin
      pulse_left--;
      if (pulse_left == 0) m_byte_n = 1;
    end
`endif
  endtask

  task automatic cycle(input logic rst, md, hc, hb, so, c, ack, input logic [7:0] di);
    @(negedge clk);
    reset = rst; mode = md; hclk = hc; hf = hb; soe = so; ce = c; byte_ack = ack; din = di;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] b, input logic so, input logic eht,
                          input logic [7:0] prev, input logic ebn_last);
    for (int i = 7; i >= 1; i--) add(0, 1, 1, b[i], so, 0, 8'h00, eht, prev, 1, 1);
    add(0, 1, 1, b[0], so, 0, 8'h00, eht, b, 1, ebn_last);
  endtask

  task automatic add_sync(input logic [7:0] prev);
    for (int i = 1; i <= 7; i++) add(0, 1, 1, 1, 0, 0, 8'h00, 0, prev, 1, 1);
    add(0, 1, 1, 1, 0, 0, 8'h00, 0, 8'hFF, 1, 1);
    add(0, 1, 1, 1, 0, 0, 8'h00, 0, 8'hFF, 1, 1);
    add(0, 1, 1, 1, 0, 0, 8'h00, 0, 8'hFF, 0, 1);
  endtask

  initial begin
    logic [7:0] wexp;
    logic [7:0] wexp2;
    reset = 1; mode = 1; hclk = 0; hf = 0; soe = 0; ce = 0; byte_ack = 0; din = 0;

    // Read: sync then 0x52 with soe=1, timed pulse
    add(1, 1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1);
    add_sync(8'h00);
    add_byte(8'h52, 1, 0, 8'hFF, 0);
    add(0, 1, 0, 0, 1, 1, 8'h00, 0, 8'h52, 1, 0);
    add(0, 1, 0, 0, 1, 0, 8'h00, 0, 8'h52, 1, 0);
    add(0, 1, 0, 0, 1, 1, 8'h00, 0, 8'h52, 1, 1);
    add(0, 1, 0, 0, 1, 1, 8'h00, 0, 8'h52, 1, 1);
    // soe=0: byte latched, no strobe
    add_sync(8'h52);
    add_byte(8'h35, 0, 0, 8'hFF, 1);
    // Write: A5 loaded at mode change, 3C reloaded at 8th strobe
    add(0, 0, 0, 0, 1, 0, 8'hA5, 0, 8'h35, 1, 1);
    wexp = 8'hA5;
    for (int i = 7; i >= 0; i--)
      add(0, 0, 1, 0, 1, 0, 8'h3C, wexp[i], 8'h35, 1, (i == 0) ? 1'b0 : 1'b1);
    add(0, 0, 1, 0, 1, 1, 8'h3C, 0, 8'h35, 1, 0);
    add(0, 0, 1, 0, 1, 1, 8'h3C, 0, 8'h35, 1, 1);
    add(0, 0, 1, 0, 1, 0, 8'h3C, 1, 8'h35, 1, 1);
    add(0, 0, 1, 0, 1, 0, 8'h3C, 1, 8'h35, 1, 1);
    // Reset mid-byte discards partial bits
    add(0, 1, 0, 0, 1, 0, 8'h00, 1, 8'h35, 1, 1);
    wexp2 = 8'hB0;
    for (int i = 7; i >= 4; i--) add(0, 1, 1, wexp2[i], 1, 0, 8'h00, 1, 8'h35, 1, 1);
    add(1, 1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1);
    add_byte(8'hC6, 1, 0, 8'h00, 0);
    add(0, 1, 0, 0, 1, 1, 8'h00, 0, 8'hC6, 1, 0);
    add(0, 1, 0, 0, 1, 1, 8'h00, 0, 8'hC6, 1, 1);
    // Mode change swallows coincident hclk
    add(1, 1, 0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1);
    add(0, 0, 1, 1, 1, 0, 8'h80, 0, 8'h00, 1, 1);
    add(0, 0, 1, 0, 1, 0, 8'h80, 1, 8'h00, 1, 1);
    add(0, 0, 1, 0, 1, 0, 8'h80, 0, 8'h00, 1, 1);

    foreach (tbl[k]) begin
      cycle(tbl[k].rst, tbl[k].md, tbl[k].hc, tbl[k].hb, tbl[k].so, tbl[k].ce, 1'b0, tbl[k].di);
      check($sformatf("vec%0d_ht", k), {7'd0, ht}, {7'd0, tbl[k].e_ht});
      check($sformatf("vec%0d_dout", k), dout, tbl[k].e_dout);
      check($sformatf("vec%0d_sync_n", k), {7'd0, sync_n}, {7'd0, tbl[k].e_sync_n});
      check($sformatf("vec%0d_byte_n", k), {7'd0, byte_n}, {7'd0, tbl[k].e_byte_n});
    end

    // Randomized run against the model
    cycle(1, 1, 0, 0, 1, 0, 0, 8'h00);
    for (int t = 0; t < 4000; t++) begin
      logic md;
      md = ($urandom_range(0, 63) == 0) ? !mode : mode;
      cycle(($urandom_range(0, 499) == 0), md, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
            8'($urandom));
      check("rnd_ht", {7'd0, ht}, {7'd0, m_ht});
      check("rnd_dout", dout, m_dout);
      check("rnd_sync_n", {7'd0, sync_n}, {7'd0, m_sync_n});
      check("rnd_byte_n", {7'd0, byte_n}, {7'd0, m_byte_n});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
